lda_line_queue: RTL and testbench

LDA_LINE_QUEUE -- requirements
Module: lda_line_queue

---
 rtl/lda_pkg.sv | 24 ++
 rtl/lda_cmd_fifo.sv | 54 +++++
 rtl/lda_line_queue.sv | 93 +++++++++
 tb/tb_lda_line_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lda_pkg.sv
// Shared types for the line-draw command queue: coordinate widths, the
// command record and the issue FSM states.
package lda_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;
  localparam int unsigned C_W = 3;
  localparam int unsigned CMD_W = 2 * X_W + 2 * Y_W + C_W;

  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] y1;
    logic [C_W-1:0] color;
  } lda_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } lda_state_t;

endpackage

// File: rtl/lda_cmd_fifo.sv
// Pointer-based command FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart; flush drops every stored entry.
module lda_cmd_fifo
  import lda_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_push,
  input  lda_cmd_t               i_wdata,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output lda_cmd_t               o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  lda_cmd_t        mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  assign o_empty     = (wr_ptr_q == rd_ptr_q);
  assign o_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_occupancy = wr_ptr_q - rd_ptr_q;
  assign o_rdata     = mem_q[rd_ptr_q[AW-1:0]];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (i_flush) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/lda_line_queue.sv
// Line command queue: buffers endpoint/colour commands and hands them one at a
// time to the line engine with a start pulse, waiting for done between commands.
module lda_line_queue
  import lda_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [X_W-1:0]               i_cmd_x0,
  input  logic [X_W-1:0]               i_cmd_x1,
  input  logic [Y_W-1:0]               i_cmd_y0,
  input  logic [Y_W-1:0]               i_cmd_y1,
  input  logic [C_W-1:0]               i_cmd_color,
  input  logic                         i_flush,
  output logic [X_W-1:0]               o_x0,
  output logic [X_W-1:0]               o_x1,
  output logic [Y_W-1:0]               o_y0,
  output logic [Y_W-1:0]               o_y1,
  output logic [C_W-1:0]               o_color,
  output logic                         o_start,
  input  logic                         i_done,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

  lda_state_t  state_q, state_d;
  lda_cmd_t    cmd_q;
  lda_cmd_t    fifo_wdata;
  lda_cmd_t    fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_occ;
  logic        pop;

  assign fifo_wdata = '{x0: i_cmd_x0, x1: i_cmd_x1, y0: i_cmd_y0, y1: i_cmd_y1,
                        color: i_cmd_color};

  lda_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_push      (i_cmd_valid),
    .i_wdata     (fifo_wdata),
    .i_pop       (pop),
    .i_flush     (i_flush),
    .o_rdata     (fifo_rdata),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_occupancy (fifo_occ)
  );

  assign pop = (state_q == StIdle) && !fifo_empty && !i_flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (i_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= StIdle;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= fifo_rdata;
    end
  end

  assign o_cmd_ready = !fifo_full;
  assign o_start     = (state_q == StIssue);
  // The command held by the engine counts as outstanding until done.
  assign o_count     = CW'(fifo_occ) + CW'(state_q != StIdle);
  assign o_busy      = (o_count != '0);

  assign o_x0    = cmd_q.x0;
  assign o_x1    = cmd_q.x1;
  assign o_y0    = cmd_q.y0;
  assign o_y1    = cmd_q.y1;
  assign o_color = cmd_q.color;

endmodule

// File: tb/tb_lda_line_queue.sv
// Scoreboard bench for lda_line_queue: accepted commands are queued as
// expectations and matched against the registered outputs at each start pulse.
module tb_lda_line_queue;
  import lda_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1) + 1;

  logic           i_clk;
  logic           i_resetn;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [X_W-1:0] i_cmd_x0, i_cmd_x1;
  logic [Y_W-1:0] i_cmd_y0, i_cmd_y1;
  logic [C_W-1:0] i_cmd_color;
  logic           i_flush;
  logic [X_W-1:0] o_x0, o_x1;
  logic [Y_W-1:0] o_y0, o_y1;
  logic [C_W-1:0] o_color;
  logic           o_start;
  logic           i_done;
  logic           o_busy;
  logic [CW-1:0]  o_count;

  lda_line_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_x0    (i_cmd_x0),
    .i_cmd_x1    (i_cmd_x1),
    .i_cmd_y0    (i_cmd_y0),
    .i_cmd_y1    (i_cmd_y1),
    .i_cmd_color (i_cmd_color),
    .i_flush     (i_flush),
    .o_x0        (o_x0),
    .o_x1        (o_x1),
    .o_y0        (o_y0),
    .o_y1        (o_y1),
    .o_color     (o_color),
    .o_start     (o_start),
    .i_done      (i_done),
    .o_busy      (o_busy),
    .o_count     (o_count)
  );

  int       n_checks = 0;
  int       n_errors = 0;
  int       n_starts = 0;
  lda_cmd_t exp_q[$];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lda_cmd_t mk_cmd(input int k);
    lda_cmd_t c;
    c.x0    = 9'(k * 37 + 5);
    c.x1    = 9'(300 - k * 11);
    c.y0    = 8'(k * 13 + 1);
    c.y1    = 8'(200 - k * 7);
    c.color = 3'(k + 1);
    return c;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_cmd(input lda_cmd_t c);
    i_cmd_x0    = c.x0;
    i_cmd_x1    = c.x1;
    i_cmd_y0    = c.y0;
    i_cmd_y1    = c.y1;
    i_cmd_color = c.color;
  endtask

  // Callers only push when the model says there is room.
  task automatic do_push(input lda_cmd_t c);
    drive_cmd(c);
    i_cmd_valid = 1'b1;
    check("push_ready", 64'(o_cmd_ready), 64'd1);
    exp_q.push_back(c);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!o_start && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(o_start), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, 64'(o_start), 64'd0);
    check({tag, "_count"}, 64'(o_count), 64'd0);
    check({tag, "_busy"},  64'(o_busy), 64'd0);
    check({tag, "_ready"}, 64'(o_cmd_ready), 64'd1);
    check({tag, "_data"},  64'({o_x0, o_x1, o_y0, o_y1, o_color}), 64'd0);
  endtask

  always @(negedge i_clk) begin
    if (i_resetn && o_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("start_unexpected", 64'(o_start), 64'd0);
      end else begin
        lda_cmd_t e;
        e = exp_q.pop_front();
        check("cmd_order", 64'({o_x0, o_x1, o_y0, o_y1, o_color}), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    lda_cmd_t one;
    int       starts0;
    i_resetn    = 1'b0;
    i_cmd_valid = 1'b0;
    i_flush     = 1'b0;
    i_done      = 1'b0;
    drive_cmd('0);
    #3;
    check_idle_outputs("reset");
    repeat (2) @(negedge i_clk);
    i_resetn = 1'b1;
    tick();

    // Single command with a 10-cycle engine.
    one = '{x0: 9'd0, x1: 9'd319, y0: 8'd0, y1: 8'd239, color: 3'd7};
    do_push(one);
    check("no_bypass", 64'(o_start), 64'd0);
    check("single_cnt", 64'(o_count), 64'd1);
    tick();
    check("lat_start", 64'(o_start), 64'd1);
    check("lat_data", 64'({o_x0, o_x1, o_y0, o_y1, o_color}), 64'(one));
    tick();
    check("start_1cyc", 64'(o_start), 64'd0);
    repeat (9) tick();
    check("busy_wait", 64'(o_busy), 64'd1);
    check("hold_data", 64'({o_x0, o_x1, o_y0, o_y1, o_color}), 64'(one));
    finish_cmd();
    check("busy_fall", 64'(o_busy), 64'd0);
    check("single_starts", 64'(n_starts), 64'd1);

    // Fill: one issued, DEPTH queued.
    for (int k = 0; k < 5; k++) do_push(mk_cmd(k));
    check("fill_cnt", 64'(o_count), 64'd5);
    check("fill_ready", 64'(o_cmd_ready), 64'd0);
    drive_cmd(mk_cmd(99));
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check("full_cnt", 64'(o_count), 64'd5);
    check("full_ready", 64'(o_cmd_ready), 64'd0);

    // Drain in order; a done during ISSUE must be ignored.
    for (int k = 0; k < 5; k++) begin
      check("drain_cnt", 64'(o_count), 64'(5 - k));
      finish_cmd();
      check("drain_cnt_done", 64'(o_count), 64'(4 - k));
      if (k < 4) begin
        wait_start("drain_start");
        i_done = (k == 0);
        tick();
        i_done = 1'b0;
      end
    end
    check("drain_starts", 64'(n_starts), 64'd6);

    // Push and pop on the same edge.
    do_push(mk_cmd(30));
    do_push(mk_cmd(31));
    do_push(mk_cmd(32));
    check("sim_pre_cnt", 64'(o_count), 64'd3);
    finish_cmd();
    check("sim_idle_cnt", 64'(o_count), 64'd2);
    do_push(mk_cmd(33));
    check("sim_cnt", 64'(o_count), 64'd3);
    check("sim_start", 64'(o_start), 64'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      finish_cmd();
      wait_start("sim_drain");
    end
    tick();
    finish_cmd();
    check("sim_end_cnt", 64'(o_count), 64'd0);

    // Flush with a same-cycle push while one command is in flight.
    do_push(mk_cmd(10));
    wait_start("fl_start");
    for (int k = 11; k < 14; k++) do_push(mk_cmd(k));
    check("fl_pre_cnt", 64'(o_count), 64'd4);
    exp_q.delete();
    drive_cmd(mk_cmd(14));
    i_cmd_valid = 1'b1;
    i_flush     = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_flush     = 1'b0;
    check("fl_cnt", 64'(o_count), 64'd1);
    check("fl_ready", 64'(o_cmd_ready), 64'd1);
    check("fl_busy", 64'(o_busy), 64'd1);
    starts0 = n_starts;
    finish_cmd();
    check("fl_done_cnt", 64'(o_count), 64'd0);
    repeat (5) tick();
    check("fl_nostart", 64'(n_starts), 64'(starts0));

    // Asynchronous reset in WAIT with one queued command.
    do_push(mk_cmd(20));
    wait_start("rst_pre_start");
    tick();
    do_push(mk_cmd(21));
    check("rst_pre_cnt", 64'(o_count), 64'd2);
    #2;
    i_resetn = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    exp_q.delete();
    i_done = 1'b1;
    @(negedge i_clk);
    i_resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_nostart", 64'(o_start), 64'd0);
    end
    check("rst_cnt", 64'(o_count), 64'd0);
    i_done = 1'b0;
    do_push(mk_cmd(22));
    wait_start("rst_new_start");
    tick();
    finish_cmd();
    check("rst_end_cnt", 64'(o_count), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
